icache_nway: RTL

- Parametrised set-associative successor to the direct-mapped instruction cache; sits between PC/fetch stage and instruction memory.
- Lookup is combinational over all ways. On a miss it stalls fetch, refills the line itself from memory over a beat-per-word valid handshake, then resumes.
- Adds per-set round-robin replacement and a whole-cache flush (for FENCE.I).

---
 rtl/icache_nway_if.sv | 24 ++
 rtl/icache_nway.sv | 139 +++++++++++++
 2 files changed

// File: rtl/icache_nway_if.sv
// icache_nway_if: fetch-side lookup signals and memory-side refill handshake of icache_nway.
// The cache is the slave; the fetch stage and the instruction memory together act as master.
interface icache_nway_if;
  logic [31:0] PC;
  logic        req;
  logic        flush;
  logic [31:0] rd;
  logic        hit;
  logic        stall;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  modport slave (
    input  PC, req, flush, mem_valid, mem_data,
    output rd, hit, stall, mem_rd, mem_addr
  );

  modport master (
    output PC, req, flush, mem_valid, mem_data,
    input  rd, hit, stall, mem_rd, mem_addr
  );
endinterface

// File: rtl/icache_nway.sv
// icache_nway: set-associative instruction cache with combinational lookup,
// self-managed beat-per-word line refill, per-set round-robin replacement and whole-cache flush.
module icache_nway #(
  parameter int WAYS           = 2,
  parameter int SETS           = 16,
  parameter int WORDS_PER_LINE = 8
) (
  input logic          CLK,
  input logic          RST,
  icache_nway_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t           state;
  logic [WAYS-1:0]  valid    [SETS];
  logic [WAY_W-1:0] rr       [SETS];
  logic [TAG_W-1:0] tag_arr  [SETS][WAYS];
  logic [31:0]      data_arr [SETS][WAYS][WORDS_PER_LINE];

  logic [OFF_W-1:0] beat;
  logic             flush_pending;
  logic             mem_rd_q;
  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_set;
  logic [WAY_W-1:0] fill_way;
  logic             fill_from_rr;

  logic [IDX_W-1:0] pc_set;
  logic [OFF_W-1:0] pc_off;
  logic [TAG_W-1:0] pc_tag;
  logic             unused_pc_bits;

  assign pc_set         = bus.PC[IDX_W+OFF_W+1:OFF_W+2];
  assign pc_off         = bus.PC[OFF_W+1:2];
  assign pc_tag         = bus.PC[31:IDX_W+OFF_W+2];
  assign unused_pc_bits = ^bus.PC[1:0];

  logic             lookup_hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic             victim_from_rr;
  logic             miss;
  logic             last_beat;

  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[pc_set][w] && (tag_arr[pc_set][w] == pc_tag)) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
  end

  // Invalid ways are filled first (lowest index wins); only a full set consults rr.
  always_comb begin
    victim         = rr[pc_set];
    victim_from_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[pc_set][w]) begin
        victim         = WAY_W'(w);
        victim_from_rr = 1'b0;
      end
    end
  end

  assign bus.hit      = bus.req && (state == IDLE) && lookup_hit;
  assign miss         = bus.req && (state == IDLE) && !lookup_hit;
  assign bus.rd       = bus.hit ? data_arr[pc_set][hit_way][pc_off] : NOP;
  assign bus.stall    = miss || (state != IDLE);
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = {fill_tag, fill_set, beat, 2'b00};
  assign last_beat    = (state == REFILL) && bus.mem_valid && (beat == OFF_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      beat          <= '0;
      flush_pending <= 1'b0;
      mem_rd_q      <= 1'b0;
      fill_tag      <= '0;
      fill_set      <= '0;
      fill_way      <= '0;
      fill_from_rr  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        rr[s]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
          end else if (miss) begin
            fill_tag                <= pc_tag;
            fill_set                <= pc_set;
            fill_way                <= victim;
            fill_from_rr            <= victim_from_rr;
            valid[pc_set][victim]   <= 1'b0;
            beat                    <= '0;
            mem_rd_q                <= 1'b1;
            state                   <= REFILL;
          end
        end
        REFILL: begin
          if (bus.flush) flush_pending <= 1'b1;
          if (bus.mem_valid) beat <= beat + 1'b1;
          // A flush seen during the refill wins over validating the new line.
          if (last_beat) begin
            state         <= IDLE;
            mem_rd_q      <= 1'b0;
            flush_pending <= 1'b0;
            if (flush_pending || bus.flush) begin
              for (int s = 0; s < SETS; s++) valid[s] <= '0;
            end else begin
              valid[fill_set][fill_way] <= 1'b1;
            end
            if (fill_from_rr && (WAYS > 1)) rr[fill_set] <= fill_way + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if ((state == REFILL) && bus.mem_valid) begin
      data_arr[fill_set][fill_way][beat] <= bus.mem_data;
      if (last_beat) tag_arr[fill_set][fill_way] <= fill_tag;
    end
  end
endmodule
